inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/ifq_pkg.sv | 16 +
 rtl/ifq_fifo.sv | 59 +++++
 rtl/inst_fetch_queue.sv | 91 +++++++++
 tb/tb_inst_fetch_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared constants and the queue entry layout for the instruction fetch queue.
package ifq_pkg;

  localparam int INST_WIDTH   = 32;
  localparam int INST_BYTES   = 4;
  localparam int PC_MAX_WIDTH = 64;

  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  // The PC field is sized for the widest supported DATA_WIDTH; narrower PCs are zero-extended.
  typedef struct packed {
    logic [PC_MAX_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0]   inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Generic circular buffer with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module ifq_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop  && !flush && !empty;
  assign do_push   = push && !flush && (!full || do_pop);
  assign head_data = mem[head];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count, so clearing it only costs logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns fetch_pc and the push/pop/redirect control around ifq_fifo.
// Define IFQ_BYPASS_EN to let an empty queue present the IMem word combinationally.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  localparam int                   CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  output logic [DATA_WIDTH-1:0] out_imem_addr,
  input  logic [INST_WIDTH-1:0] in_imem_inst,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_inst_pc,
  output logic                  out_valid,
  input  logic                  in_ready,
  input  logic                  in_redirect,
  input  logic [DATA_WIDTH-1:0] in_redirect_pc,
  output logic [CNT_W-1:0]      out_count
);

  logic [DATA_WIDTH-1:0] fetch_pc;
  ifq_entry_t            push_entry;
  ifq_entry_t            head_entry;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  advance;

  assign out_imem_addr = fetch_pc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push_entry      = '0;
    push_entry.pc   = PC_MAX_WIDTH'(fetch_pc);
    push_entry.inst = in_imem_inst;

    // Redirect wins over both directions of traffic.
    fifo_pop  = !fifo_empty && in_ready && !in_redirect;
    advance   = !in_redirect && (!fifo_full || fifo_pop);
    fifo_push = advance;

    out_valid   = 1'b0;
    out_inst    = NOP_INST;
    out_inst_pc = '0;
    if (!fifo_empty) begin
      out_valid   = 1'b1;
      out_inst    = head_entry.inst;
      out_inst_pc = head_entry.pc[DATA_WIDTH-1:0];
    end
`ifdef IFQ_BYPASS_EN
    else if (!in_redirect && !in_Rst) begin
      out_valid   = 1'b1;
      out_inst    = in_imem_inst;
      out_inst_pc = fetch_pc;
      // A word taken straight from IMem is consumed without occupying a slot.
      if (in_ready) fifo_push = 1'b0;
    end
`endif
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      fetch_pc <= RESET_PC;
    end else if (in_redirect) begin
      fetch_pc <= in_redirect_pc & ~DATA_WIDTH'(INST_BYTES - 1);
    end else if (advance) begin
      fetch_pc <= fetch_pc + DATA_WIDTH'(INST_BYTES);
    end
  end

  ifq_fifo #(
    .WIDTH ($bits(ifq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (in_Clk),
    .rst       (in_Rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (in_redirect),
    .head_data (head_entry),
    .count     (out_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue (default build): directed phases queue the expected PC stream,
// a negedge monitor compares every accepted head entry against it.
module tb_inst_fetch_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          in_Clk;
  logic          in_Rst;
  logic [DW-1:0] out_imem_addr;
  logic [31:0]   in_imem_inst;
  logic [31:0]   out_inst;
  logic [DW-1:0] out_inst_pc;
  logic          out_valid;
  logic          in_ready;
  logic          in_redirect;
  logic [DW-1:0] in_redirect_pc;
  logic [CW-1:0] out_count;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  inst_fetch_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RESET_PC   ('0)
  ) dut (
    .in_Clk         (in_Clk),
    .in_Rst         (in_Rst),
    .out_imem_addr  (out_imem_addr),
    .in_imem_inst   (in_imem_inst),
    .out_inst       (out_inst),
    .out_inst_pc    (out_inst_pc),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .in_redirect    (in_redirect),
    .in_redirect_pc (in_redirect_pc),
    .out_count      (out_count)
  );

  // IMem model: each word holds the low 32 bits of its own address.
  assign in_imem_inst = out_imem_addr[31:0];

  initial in_Clk = 1'b0;
  always #5 in_Clk = ~in_Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge in_Clk);
    #1;
  endtask

  // Monitor: an entry is accepted on the coming edge when valid, ready and not redirecting.
  always @(negedge in_Clk) begin
    if (!in_Rst && out_valid && in_ready && !in_redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery actual_pc=%h expected=none", out_inst_pc);
      end else begin
        logic [63:0] exp_pc;
        exp_pc = exp_q.pop_front();
        check("deliver_pc", out_inst_pc, exp_pc);
        check("deliver_inst", {32'h0, out_inst}, {32'h0, exp_pc[31:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    in_Rst         = 1'b1;
    in_ready       = 1'b0;
    in_redirect    = 1'b0;
    in_redirect_pc = '0;
    tick(2);
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_inst",  out_inst, 32'h13);
    check("rst_pc",    out_inst_pc, 0);
    check("rst_addr",  out_imem_addr, 0);

    // Streaming with ready held: PCs 0,4,8 delivered, one cycle of push latency.
    in_Rst   = 1'b0;
    in_ready = 1'b1;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    #2;
    check("latency_before_edge", out_valid, 0);
    tick(1);
    check("latency_after_edge", out_valid, 1);
    check("addr_after_first_push", out_imem_addr, 64'h4);
    tick(3);
    in_ready = 1'b0;
    check("stream_count", out_count, 1);
    check("stream_head_pc", out_inst_pc, 64'hC);
    check("stream_addr", out_imem_addr, 64'h10);

    // Asynchronous reset pulse between edges.
    #1 in_Rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_count", out_count, 0);
    check("async_rst_inst", out_inst, 32'h13);
    check("async_rst_addr", out_imem_addr, 0);
    #1 in_Rst = 1'b0;

    // Back-pressure: queue fills to DEPTH and fetch holds at 0x10.
    tick(3);
    check("fill_count3", out_count, 3);
    tick(7);
    check("full_count", out_count, 4);
    check("full_addr_hold", out_imem_addr, 64'h10);
    for (int i = 0; i < 5; i++) exp_q.push_back(64'(4 * i));
    in_ready = 1'b1;
    tick(1);
    check("push_pop_full_count", out_count, 4);
    check("push_pop_full_addr", out_imem_addr, 64'h14);
    tick(4);
    in_ready = 1'b0;
    check("wrap_count", out_count, 4);
    check("wrap_head_pc", out_inst_pc, 64'h14);

    // Redirect from a full queue.
    in_redirect    = 1'b1;
    in_redirect_pc = 64'h200;
    tick(1);
    check("redir_count", out_count, 0);
    check("redir_valid", out_valid, 0);
    check("redir_addr", out_imem_addr, 64'h200);
    check("redir_inst_nop", out_inst, 32'h13);
    in_redirect = 1'b0;
    in_ready    = 1'b1;
    exp_q.push_back(64'h200);
    tick(2);
    check("redir_head_next", out_inst_pc, 64'h204);

    // Misaligned redirect target is forced to a word boundary.
    in_redirect    = 1'b1;
    in_redirect_pc = 64'h203;
    tick(1);
    check("align_addr", out_imem_addr, 64'h200);
    check("align_count", out_count, 0);
    in_redirect = 1'b0;
    exp_q.push_back(64'h200);
    tick(2);

    // Fetch address wraps at the top of the address space.
    in_redirect    = 1'b1;
    in_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(1);
    check("top_addr", out_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    in_redirect = 1'b0;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0);
    tick(1);
    check("wrap_addr_zero", out_imem_addr, 64'h0);
    check("wrap_head_top", out_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(2);
    in_ready = 1'b0;

    tick(2);
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
